// File: rtl/irq_trap_ctrl_if.sv
// Core-side bundle for irq_trap_ctrl: CSR access port plus the trap entry/return handshake.
// The core is the master and the controller is the slave.
interface irq_trap_ctrl_if;
  logic        csr_valid;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic        csr_hit;
  logic [31:0] csr_rdata;
  logic        csr_ready;
  logic        insn_boundary;
  logic [31:0] pc;
  logic        mret;
  logic        trap_req;
  logic        trap_ack;
  logic [31:0] trap_vector;
  logic [31:0] mepc_out;

  modport master (
    output csr_valid, csr_addr, csr_we, csr_wdata, insn_boundary, pc, mret, trap_ack,
    input  csr_hit, csr_rdata, csr_ready, trap_req, trap_vector, mepc_out
  );

  modport slave (
    input  csr_valid, csr_addr, csr_we, csr_wdata, insn_boundary, pc, mret, trap_ack,
    output csr_hit, csr_rdata, csr_ready, trap_req, trap_vector, mepc_out
  );
endinterface

// File: rtl/irq_trap_ctrl.sv
// Machine-mode interrupt/trap controller: msip/mtip/meip pending logic, M-mode CSRs,
// trap entry request at instruction boundaries and mret handling.
//   state | meaning
//   IDLE  | no trap outstanding, sampling pending interrupts at boundaries
//   REQ   | trap_req high, cause/pc/vector frozen until trap_ack
module irq_trap_ctrl #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic clk,
  input  logic resetn,
  input  logic irq_msip,
  input  logic irq_mtip,
  input  logic irq_meip,
  irq_trap_ctrl_if.slave bus
);
  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MIP     = 12'h344;

  typedef enum logic {IDLE, REQ} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] meip_sync;
  logic        meip_s;
  logic        mst_mie, mst_mpie;
  logic [31:0] mie_r, mtvec, mepc, mcause;
  logic [31:0] mip, pend, mstatus_rd;
  logic [31:0] cause_lat, pc_lat, vec_lat;
  logic [31:0] cause_nxt, vec_nxt, rd_mux;
  logic [4:0]  code;
  logic        csr_hit, csr_ready_q, accept, wr;
  logic        take, ack;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) meip_sync <= '0;
    else         meip_sync <= {meip_sync[SYNC_STAGES-2:0], irq_meip};
  end
  assign meip_s = meip_sync[SYNC_STAGES-1];

  assign mip        = {20'b0, meip_s, 3'b0, irq_mtip, 3'b0, irq_msip, 3'b0};
  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mst_mpie, 3'b0, mst_mie, 3'b0};
  assign pend       = mip & mie_r & {32{mst_mie}};

  // Fixed priority MEI > MSI > MTI
  always_comb begin
    code = 5'd7;
    if (pend[11])     code = 5'd11;
    else if (pend[3]) code = 5'd3;
  end
  assign cause_nxt = 32'h8000_0000 | {27'b0, code};
  assign vec_nxt   = mtvec[0] ? ({mtvec[31:2], 2'b00} + {25'b0, code, 2'b00})
                              : {mtvec[31:2], 2'b00};

  always_comb begin
    csr_hit = 1'b0;
    rd_mux  = 32'h0;
    case (bus.csr_addr)
      A_MSTATUS: begin csr_hit = 1'b1; rd_mux = mstatus_rd; end
      A_MIE:     begin csr_hit = 1'b1; rd_mux = mie_r;      end
      A_MTVEC:   begin csr_hit = 1'b1; rd_mux = mtvec;      end
      A_MEPC:    begin csr_hit = 1'b1; rd_mux = mepc;       end
      A_MCAUSE:  begin csr_hit = 1'b1; rd_mux = mcause;     end
      A_MIP:     begin csr_hit = 1'b1; rd_mux = mip;        end
      default:   begin csr_hit = 1'b0; rd_mux = 32'h0;      end
    endcase
  end

  assign accept = bus.csr_valid && csr_hit && !csr_ready_q;
  assign wr     = accept && bus.csr_we;

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    ack       = 1'b0;
    case (state)
      IDLE: if (bus.insn_boundary && |pend && !bus.mret) begin
        take      = 1'b1;
        state_nxt = REQ;
      end
      REQ: if (bus.trap_ack) begin
        ack       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cause_lat <= '0;
      pc_lat    <= '0;
      vec_lat   <= '0;
    end else if (take) begin
      cause_lat <= cause_nxt;
      pc_lat    <= bus.pc;
      vec_lat   <= vec_nxt;
    end
  end

  // Trap entry outranks mret, which outranks a software write of mstatus
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mst_mie  <= 1'b0;
      mst_mpie <= 1'b0;
    end else if (ack) begin
      mst_mpie <= mst_mie;
      mst_mie  <= 1'b0;
    end else if (bus.mret) begin
      mst_mie  <= mst_mpie;
      mst_mpie <= 1'b1;
    end else if (wr && bus.csr_addr == A_MSTATUS) begin
      mst_mie  <= bus.csr_wdata[3];
      mst_mpie <= bus.csr_wdata[7];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mie_r  <= '0;
      mtvec  <= MTVEC_RESET;
      mepc   <= '0;
      mcause <= '0;
    end else begin
      if (wr && bus.csr_addr == A_MIE)
        mie_r <= bus.csr_wdata & 32'h0000_0888;
      if (wr && bus.csr_addr == A_MTVEC)
        mtvec <= {bus.csr_wdata[31:2], 1'b0, bus.csr_wdata[1:0] == 2'b01};
      if (ack) begin
        mepc   <= pc_lat;
        mcause <= cause_lat;
      end else begin
        if (wr && bus.csr_addr == A_MEPC)   mepc   <= {bus.csr_wdata[31:2], 2'b00};
        if (wr && bus.csr_addr == A_MCAUSE) mcause <= bus.csr_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      csr_ready_q   <= 1'b0;
      bus.csr_rdata <= '0;
    end else begin
      csr_ready_q <= accept;
      if (accept) bus.csr_rdata <= rd_mux;
    end
  end

  assign bus.csr_hit     = csr_hit;
  assign bus.csr_ready   = csr_ready_q;
  assign bus.trap_req    = (state == REQ);
  assign bus.trap_vector = vec_lat;
  assign bus.mepc_out    = mepc;
endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Directed bench for irq_trap_ctrl: CSR map, trap entry/ack, mret, priority,
// meip synchronizer latency and same-edge conflicts.
module tb_irq_trap_ctrl;
  localparam logic [31:0] MTVEC_RST = 32'h2000_0000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic irq_msip = 1'b0, irq_mtip = 1'b0, irq_meip = 1'b0;
  int checks = 0;
  int errors = 0;

  irq_trap_ctrl_if bus();

  irq_trap_ctrl #(.SYNC_STAGES(2), .MTVEC_RESET(MTVEC_RST)) dut (
    .clk(clk), .resetn(resetn),
    .irq_msip(irq_msip), .irq_mtip(irq_mtip), .irq_meip(irq_meip),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic csr_acc(input logic [11:0] a, input logic we, input logic [31:0] wd,
                         output logic [31:0] rd);
    bus.csr_valid = 1'b1;
    bus.csr_addr  = a;
    bus.csr_we    = we;
    bus.csr_wdata = wd;
    @(negedge clk);
    chk("csr_ready", 32'(bus.csr_ready), 32'd1);
    rd = bus.csr_rdata;
    bus.csr_valid = 1'b0;
    bus.csr_we    = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    csr_acc(a, 1'b1, d, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] v;
    csr_acc(a, 1'b0, 32'h0, v);
    chk(tag, v, exp);
  endtask

  task automatic boundary(input logic [31:0] p);
    bus.pc = p;
    bus.insn_boundary = 1'b1;
    @(negedge clk);
    bus.insn_boundary = 1'b0;
  endtask

  task automatic ack_pulse();
    bus.trap_ack = 1'b1;
    @(negedge clk);
    bus.trap_ack = 1'b0;
  endtask

  initial begin
    bus.csr_valid = 0; bus.csr_addr = '0; bus.csr_we = 0; bus.csr_wdata = '0;
    bus.insn_boundary = 0; bus.pc = '0; bus.mret = 0; bus.trap_ack = 0;
    repeat (2) @(negedge clk);
    chk("rst_trap_req", 32'(bus.trap_req), 32'd0);
    chk("rst_csr_ready", 32'(bus.csr_ready), 32'd0);
    chk("rst_rdata", bus.csr_rdata, 32'h0);
    chk("rst_mepc_out", bus.mepc_out, 32'h0);
    resetn = 1'b1;
    @(negedge clk);
    rd_chk("rst_mtvec", 12'h305, MTVEC_RST);
    rd_chk("rst_mstatus", 12'h300, 32'h0000_1800);
    rd_chk("rst_mip", 12'h344, 32'h0);

    // direct-mode timer trap, held request with source dropped
    wr(12'h305, 32'h8000_0000);
    wr(12'h304, 32'h0000_0080);
    wr(12'h300, 32'h0000_0008);
    irq_mtip = 1'b1;
    boundary(32'h100);
    chk("t2_req", 32'(bus.trap_req), 32'd1);
    chk("t2_vec", bus.trap_vector, 32'h8000_0000);
    irq_mtip = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_req_hold", 32'(bus.trap_req), 32'd1);
      chk("t4_vec_hold", bus.trap_vector, 32'h8000_0000);
    end
    ack_pulse();
    chk("t2_req_clr", 32'(bus.trap_req), 32'd0);
    chk("t2_mepc_out", bus.mepc_out, 32'h100);
    rd_chk("t2_mepc", 12'h341, 32'h100);
    rd_chk("t2_mcause", 12'h342, 32'h8000_0007);
    rd_chk("t2_mstatus", 12'h300, 32'h0000_1880);
    ack_pulse();
    rd_chk("idle_ack_mstatus", 12'h300, 32'h0000_1880);

    // mret restores MIE; pending mtip retriggers at next boundary
    irq_mtip = 1'b1;
    bus.mret = 1'b1;
    @(negedge clk);
    bus.mret = 1'b0;
    rd_chk("t5_mstatus", 12'h300, 32'h0000_1888);
    chk("t5_no_req", 32'(bus.trap_req), 32'd0);
    boundary(32'h200);
    chk("t5_req", 32'(bus.trap_req), 32'd1);
    ack_pulse();
    chk("t5_mepc_out", bus.mepc_out, 32'h200);
    irq_mtip = 1'b0;

    // vectored mode, all three pending, meip through synchronizer
    wr(12'h305, 32'h8000_0001);
    wr(12'h304, 32'h0000_0888);
    wr(12'h300, 32'h0000_0008);
    irq_msip = 1'b1; irq_mtip = 1'b1; irq_meip = 1'b1;
    rd_chk("t3_mip_presync", 12'h344, 32'h0000_0088);
    rd_chk("t3_mip_sync", 12'h344, 32'h0000_0888);
    boundary(32'h300);
    chk("t3_req", 32'(bus.trap_req), 32'd1);
    chk("t3_vec", bus.trap_vector, 32'h8000_002C);
    ack_pulse();
    rd_chk("t3_mcause", 12'h342, 32'h8000_000B);
    rd_chk("t3_mepc", 12'h341, 32'h300);
    irq_meip = 1'b0;
    wr(12'h300, 32'h0000_0008);
    boundary(32'h400);
    chk("msi_vec", bus.trap_vector, 32'h8000_000C);
    ack_pulse();
    rd_chk("msi_mcause", 12'h342, 32'h8000_0003);

    // CSR field behaviour and unmapped address
    wr(12'h341, 32'h0000_1003);
    rd_chk("t6_mepc_align", 12'h341, 32'h0000_1000);
    bus.csr_valid = 1'b1; bus.csr_addr = 12'h7C0; bus.csr_we = 1'b0;
    #1;
    chk("t6_hit", 32'(bus.csr_hit), 32'd0);
    @(negedge clk);
    chk("t6_ready0", 32'(bus.csr_ready), 32'd0);
    @(negedge clk);
    chk("t6_ready1", 32'(bus.csr_ready), 32'd0);
    bus.csr_valid = 1'b0;
    @(negedge clk);
    wr(12'h305, 32'h8000_0002);
    rd_chk("mtvec_mode2", 12'h305, 32'h8000_0000);
    wr(12'h304, 32'hFFFF_FFFF);
    rd_chk("mie_mask", 12'h304, 32'h0000_0888);
    wr(12'h344, 32'hFFFF_FFFF);
    rd_chk("mip_ro", 12'h344, 32'h0000_0088);

    // trap_ack and mstatus write on the same edge
    wr(12'h300, 32'h0000_0008);
    boundary(32'h500);
    chk("t6_req", 32'(bus.trap_req), 32'd1);
    bus.trap_ack = 1'b1;
    bus.csr_valid = 1'b1; bus.csr_addr = 12'h300; bus.csr_we = 1'b1; bus.csr_wdata = 32'h0;
    @(negedge clk);
    chk("t6_ready", 32'(bus.csr_ready), 32'd1);
    chk("t6_req_clr", 32'(bus.trap_req), 32'd0);
    bus.trap_ack = 1'b0; bus.csr_valid = 1'b0; bus.csr_we = 1'b0;
    @(negedge clk);
    rd_chk("t6_ack_wins", 12'h300, 32'h0000_1880);
    rd_chk("t6_mepc", 12'h341, 32'h500);

    // reset while requesting
    wr(12'h300, 32'h0000_0008);
    boundary(32'h600);
    chk("mid_req", 32'(bus.trap_req), 32'd1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_req", 32'(bus.trap_req), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    irq_msip = 1'b0; irq_mtip = 1'b0;
    @(negedge clk);
    rd_chk("mid_rst_mtvec", 12'h305, MTVEC_RST);
    rd_chk("mid_rst_mstatus", 12'h300, 32'h0000_1800);
    chk("mid_rst_mepc", bus.mepc_out, 32'h0);
    chk("mid_rst_idle", 32'(bus.trap_req), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
